uart_tx_fifo: RTL and testbench

Buffered UART transmitter: accepts bytes on a single-cycle write strobe into an internal FIFO and serializes them as 8N1 frames on one serial line. It sits between the board-level control logic (switch/keyboard/board forwarding) and the RsTx / JB pins. Simultaneous or back-to-back send requests queue instead of overwriting an in-flight byte. Bit timing is generated internally from the system clock.

---
 rtl/uart_tx_fifo_if.sv | 29 ++
 rtl/uart_tx_fifo.sv | 158 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write-side and line-side signals of the buffered UART
// transmitter.
//   wr_data/wr_en : byte and enqueue strobe (master -> slave)
//   full/count    : FIFO occupancy, registered (slave -> master)
//   overflow      : one-cycle pulse after a write was dropped
//   busy/tx       : frame-in-progress flag and the serial line
interface uart_tx_fifo_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    wr_data;
    logic          wr_en;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          busy;
    logic          tx;

    modport master (
        output wr_data, wr_en,
        input  full, count, overflow, busy, tx
    );

    modport slave (
        input  wr_data, wr_en,
        output full, count, overflow, busy, tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 serializer.
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous, active-low; clears FIFO, FSM and forces tx high
//   bus   : uart_tx_fifo_if slave (wr_data, wr_en in; full, count,
//           overflow, busy, tx out)
// Bytes written while a frame is on the line queue up; the FSM pops the
// next byte from IDLE, so consecutive frames are separated by one idle
// cycle. count excludes the byte currently being shifted.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DEPTH        = 8
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------- FIFO storage and bookkeeping ----------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q, count_n;
    logic          full_q;
    logic          ovf_q;

    // ---------------- serializer state ----------------
    state_t        state_q, state_n;
    logic [BW-1:0] baud_q, baud_n;
    logic [2:0]    bit_q, bit_n;
    logic [7:0]    shift_q, shift_n;
    logic          tx_q, tx_n;
    logic          busy_q, busy_n;

    logic wr_acc;
    logic pop;
    logic baud_end;

    // full is the registered pre-edge value, so a write colliding with a
    // pop from a full FIFO is still rejected.
    assign wr_acc   = bus.wr_en && !full_q;
    assign pop      = (state_q == IDLE) && (count_q != '0);
    assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        count_n = count_q;
        if (wr_acc && !pop)
            count_n = count_q + 1'b1;
        else if (!wr_acc && pop)
            count_n = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_n;
            full_q  <= (count_n == CW'(DEPTH));
            ovf_q   <= bus.wr_en && full_q;
        end
    end

    // Storage needs no reset: count and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= bus.wr_data;
    end

    // ---------------- frame FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            baud_q  <= baud_n;
            bit_q   <= bit_n;
            shift_q <= shift_n;
            tx_q    <= tx_n;
            busy_q  <= busy_n;
        end
    end

    // The baud counter is zeroed on every state entry; within a bit period
    // it just counts up to CLKS_PER_BIT-1.
    always_comb begin
        state_n = state_q;
        baud_n  = baud_q + 1'b1;
        bit_n   = bit_q;
        shift_n = shift_q;
        case (state_q)
            IDLE: begin
                baud_n = '0;
                if (pop) begin
                    state_n = START;
                    shift_n = mem[rd_ptr];
                end
            end
            START: begin
                if (baud_end) begin
                    state_n = DATA;
                    baud_n  = '0;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (bit_q == 3'd7)
                        state_n = STOP;
                    else
                        bit_n = bit_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    state_n = IDLE;
                    baud_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // tx and busy are decoded from the next state and registered, so the
    // line changes on the same edge as the state and never glitches.
    always_comb begin
        tx_n   = 1'b1;
        busy_n = (state_n != IDLE);
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[bit_n];
            default: tx_n = 1'b1;
        endcase
    end

    assign bus.full     = full_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = busy_q;
    assign bus.tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with CLKS_PER_BIT=4 and
// DEPTH=4. A negedge line monitor decodes frames into rxq/stq; the stimulus
// block checks occupancy, timing and decoded bytes against hand values.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // ---------------- line monitor ----------------
    logic [7:0] rxq [$];
    int         stq [$];
    bit         m_st = 0;
    int         m_cnt = 0;
    int         m_start = 0;
    logic [7:0] m_byte = '0;
    int         bcnt = 0;
    bit         ovf_seen = 0;
    bit         tx_low_seen = 0;

    always @(negedge clk) begin
        if (bus.busy) bcnt++;
        if (bus.overflow) ovf_seen = 1;
        if (reset && !bus.tx) tx_low_seen = 1;
        if (!reset) begin
            m_st = 0;
        end else if (!m_st) begin
            if (!bus.tx) begin
                m_st    = 1;
                m_cnt   = 0;
                m_start = cyc;
            end
        end else begin
            m_cnt++;
            if (m_cnt >= 6 && m_cnt <= 34 && (m_cnt - 6) % 4 == 0)
                m_byte[(m_cnt - 6) / 4] = bus.tx;
            if (m_cnt == 38) begin
                chk("rx_stop", {31'd0, bus.tx}, 32'd1);
                rxq.push_back(m_byte);
                stq.push_back(m_start);
            end
            if (m_cnt == 39) m_st = 0;
        end
    end

    function automatic logic [31:0] rx_at(input int i);
        return (i < rxq.size()) ? {24'd0, rxq[i]} : 32'hFFFF_FFFF;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one byte for exactly one rising edge; returns 1ns after it.
    task automatic wr(input logic [7:0] b);
        bus.wr_data = b;
        bus.wr_en   = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int t = 0;
        while (rxq.size() < n && t < budget) begin
            tick(1);
            t++;
        end
        chk("rx_cnt", rxq.size(), n);
    endtask

    task automatic wait_nf();
        int t = 0;
        while (bus.full && t < 200) begin
            tick(1);
            t++;
        end
        chk("nf_wait", {31'd0, bus.full}, 32'd0);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tx",    {31'd0, bus.tx},       32'd1);
        chk("rst_busy",  {31'd0, bus.busy},     32'd0);
        chk("rst_full",  {31'd0, bus.full},     32'd0);
        chk("rst_count", 32'(bus.count),        32'd0);
        chk("rst_ovf",   {31'd0, bus.overflow}, 32'd0);
        reset = 1'b1;
        tick(2);

        // single byte 0xA5 = 1010_0101, LSB first: 1,0,1,0,0,1,0,1
        bcnt = 0;
        wr(8'hA5);
        chk("s_cnt_k",   32'(bus.count),    32'd1);
        chk("s_tx_k",    {31'd0, bus.tx},   32'd1);
        chk("s_busy_k",  {31'd0, bus.busy}, 32'd0);
        tick(1);
        chk("s_tx_start", {31'd0, bus.tx},   32'd0);
        chk("s_busy_on",  {31'd0, bus.busy}, 32'd1);
        chk("s_cnt_pop",  32'(bus.count),    32'd0);
        tick(4);
        chk("s_bit0", {31'd0, bus.tx}, 32'd1);
        tick(4);
        chk("s_bit1", {31'd0, bus.tx}, 32'd0);
        tick(28);
        chk("s_stop",      {31'd0, bus.tx},   32'd1);
        chk("s_stop_busy", {31'd0, bus.busy}, 32'd1);
        tick(4);
        chk("s_end_busy", {31'd0, bus.busy}, 32'd0);
        chk("s_end_tx",   {31'd0, bus.tx},   32'd1);
        chk("s_busy_len", bcnt, 32'd40);
        wait_rx(1, 10);
        chk("s_byte", rx_at(0), 32'hA5);
        tick(3);

        // burst of 5 then overflow with 0xFF
        rxq.delete(); stq.delete(); ovf_seen = 0;
        wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04); wr(8'h05);
        chk("b_cnt",  32'(bus.count),      32'd4);
        chk("b_full", {31'd0, bus.full},   32'd1);
        chk("b_ovf",  {31'd0, ovf_seen},   32'd0);
        wr(8'hFF);
        chk("o_pulse", {31'd0, bus.overflow}, 32'd1);
        chk("o_cnt",   32'(bus.count),        32'd4);
        tick(1);
        chk("o_clear", {31'd0, bus.overflow}, 32'd0);
        chk("o_cnt2",  32'(bus.count),        32'd4);
        wait_rx(5, 400);
        for (int i = 0; i < 5; i++)
            chk($sformatf("b_byte%0d", i), rx_at(i), 32'(i + 1));
        for (int i = 0; i + 1 < stq.size(); i++)
            chk($sformatf("b_gap%0d", i), stq[i+1] - stq[i], 32'd41);
        tick(60);
        chk("o_no_ff",  rxq.size(),     32'd5);
        chk("b_cnt_end", 32'(bus.count), 32'd0);

        // write coinciding with the IDLE pop while count=1
        rxq.delete(); stq.delete();
        wr(8'h11);
        wr(8'h22);
        chk("p_cnt_a", 32'(bus.count), 32'd1);
        tick(40);
        chk("p_idle",  {31'd0, bus.busy}, 32'd0);
        chk("p_cnt_b", 32'(bus.count),    32'd1);
        wr(8'h33);
        chk("p_cnt_c", 32'(bus.count),    32'd1);
        chk("p_busy",  {31'd0, bus.busy}, 32'd1);
        chk("p_tx",    {31'd0, bus.tx},   32'd0);
        wait_rx(3, 200);
        chk("p_b0", rx_at(0), 32'h11);
        chk("p_b1", rx_at(1), 32'h22);
        chk("p_b2", rx_at(2), 32'h33);
        tick(5);

        // pointer wrap: 3*DEPTH incrementing bytes
        rxq.delete(); stq.delete();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            wait_nf();
            wr(8'(8'h30 + i));
        end
        wait_rx(3 * DEPTH, 700);
        for (int i = 0; i < 3 * DEPTH; i++)
            chk($sformatf("w_byte%0d", i), rx_at(i), 32'(8'h30 + i));
        tick(5);
        chk("w_cnt", 32'(bus.count), 32'd0);

        // reset during DATA bit 3 with 2 bytes queued; 0x50 has bit3=0
        wr(8'h50);
        wr(8'h66);
        wr(8'h77);
        tick(16);
        chk("r_bit3", {31'd0, bus.tx},   32'd0);
        chk("r_q2",   32'(bus.count),    32'd2);
        chk("r_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("r_tx",    {31'd0, bus.tx},   32'd1);
        chk("r_cnt",   32'(bus.count),    32'd0);
        chk("r_busy0", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        rxq.delete(); stq.delete(); tx_low_seen = 0;
        tick(100);
        chk("r_silent", {31'd0, tx_low_seen}, 32'd0);
        chk("r_norx",   rxq.size(),           32'd0);
        chk("r_cnt2",   32'(bus.count),       32'd0);
        chk("r_idle",   {31'd0, bus.busy},    32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1, "timeout");
    end
endmodule
